// File: rtl/tiny16_pkg.sv
// Shared types and constants for the tiny16 instruction sequencer.
// Holds the opcode, state and instruction-class enums, ALU codes and field positions.
package tiny16_pkg;

  localparam int OP_MSB = 15;
  localparam int RD_MSB = 11;
  localparam int RS_MSB = 8;
  localparam int REG_W  = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_MOV = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_LD  = 4'h7,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_F0, S_F1, S_F2, S_DEC, S_EX, S_LDM, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_MOV, CLS_ALU, CLS_LD, CLS_JMP, CLS_JZ, CLS_HLT
  } iclass_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the upper instruction bits into class, register selects and ALU code.
// Illegal opcodes report class NOP with the illegal flag raised.
module instr_decode
  import tiny16_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [15:6] word_i,
  output iclass_e     class_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs_o,
  output logic [2:0]  alu_op_o,
  output logic        illegal_o
);

  opcode_e op;

  assign op   = opcode_e'(word_i[OP_MSB -: OPW]);
  assign rd_o = word_i[RD_MSB -: REG_W];
  assign rs_o = word_i[RS_MSB -: REG_W];

  always_comb begin
    class_o   = CLS_NOP;
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (op)
      OP_NOP: class_o = CLS_NOP;
      OP_MOV: class_o = CLS_MOV;
      OP_ADD: begin class_o = CLS_ALU; alu_op_o = ALU_ADD; end
      OP_SUB: begin class_o = CLS_ALU; alu_op_o = ALU_SUB; end
      OP_AND: begin class_o = CLS_ALU; alu_op_o = ALU_AND; end
      OP_OR:  begin class_o = CLS_ALU; alu_op_o = ALU_OR;  end
      OP_XOR: begin class_o = CLS_ALU; alu_op_o = ALU_XOR; end
      OP_LD:  class_o = CLS_LD;
      OP_JMP: class_o = CLS_JMP;
      OP_JZ:  class_o = CLS_JZ;
      OP_HLT: class_o = CLS_HLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// tiny16 instruction sequencer: fetch, decode and register-file/ALU/memory strobes, all registered.
// Define TINY16_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they execute as NOP.
module control_unit
  import tiny16_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic [2:0]  src_sel,
  output logic [2:0]  dst_sel,
  output logic        reg_in_en,
  output logic        reg_out_en,
  output logic        pc_inc,
  output logic        mar_ld,
  output logic        mem_rd,
  output logic [2:0]  alu_op,
  output logic        alu_out_en,
  output logic [15:0] ir,
  output logic        halted
);

`ifdef TINY16_ILLEGAL_TRAP_EN
  localparam bit TrapIllegal = 1'b1;
`else
  localparam bit TrapIllegal = 1'b0;
`endif

  state_e      state_q;
  logic        started_q;
  logic [15:0] ir_q;
  logic [2:0]  src_sel_q, dst_sel_q, alu_op_q;
  logic        reg_in_en_q, reg_out_en_q, pc_inc_q, mar_ld_q, mem_rd_q;
  logic        alu_out_en_q, halted_q;

  logic [15:6] decWord;
  iclass_e     decClass;
  logic [2:0]  decRd, decRs, decAluOp;
  logic        decIllegal;

  // While fetching, decode the incoming word so DEC strobes can be registered on the ready edge.
  assign decWord = (state_q == S_F2) ? bus_in[15:6] : ir_q[15:6];

  instr_decode #(.OPW(OPW)) u_decode (
    .word_i    (decWord),
    .class_o   (decClass),
    .rd_o      (decRd),
    .rs_o      (decRs),
    .alu_op_o  (decAluOp),
    .illegal_o (decIllegal)
  );

  // Each edge registers the strobes of the state being entered; started_q makes the
  // first edge after reset present F0 rather than skipping past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_F0;
      started_q    <= 1'b0;
      ir_q         <= '0;
      halted_q     <= 1'b0;
      src_sel_q    <= '0;
      dst_sel_q    <= '0;
      alu_op_q     <= ALU_ADD;
      reg_in_en_q  <= 1'b0;
      reg_out_en_q <= 1'b0;
      pc_inc_q     <= 1'b0;
      mar_ld_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      alu_out_en_q <= 1'b0;
    end else begin
      src_sel_q    <= '0;
      dst_sel_q    <= '0;
      alu_op_q     <= ALU_ADD;
      reg_in_en_q  <= 1'b0;
      reg_out_en_q <= 1'b0;
      pc_inc_q     <= 1'b0;
      mar_ld_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      alu_out_en_q <= 1'b0;
      if (!started_q) begin
        started_q    <= 1'b1;
        state_q      <= S_F0;
        reg_out_en_q <= 1'b1;
      end else begin
        case (state_q)
          S_F0: begin
            state_q  <= S_F1;
            mar_ld_q <= 1'b1;
          end
          S_F1: begin
            state_q  <= S_F2;
            mem_rd_q <= 1'b1;
          end
          S_F2: begin
            if (mem_ready) begin
              state_q      <= S_DEC;
              ir_q         <= bus_in;
              pc_inc_q     <= 1'b1;
              src_sel_q    <= decRs;
              dst_sel_q    <= decRd;
              reg_out_en_q <= decClass inside {CLS_MOV, CLS_LD, CLS_JMP, CLS_JZ};
            end else begin
              mem_rd_q <= 1'b1;
            end
          end
          S_DEC: begin
            if (decClass == CLS_HLT || (decIllegal && TrapIllegal)) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (decClass == CLS_NOP) begin
              state_q      <= S_F0;
              reg_out_en_q <= 1'b1;
            end else begin
              state_q <= S_EX;
              case (decClass)
                CLS_MOV: begin
                  reg_in_en_q <= 1'b1;
                  dst_sel_q   <= decRd;
                end
                CLS_ALU: begin
                  alu_op_q     <= decAluOp;
                  alu_out_en_q <= 1'b1;
                  reg_in_en_q  <= 1'b1;
                  dst_sel_q    <= decRd;
                end
                CLS_JMP: reg_in_en_q <= 1'b1;
                CLS_JZ:  reg_in_en_q <= zero_flag;
                CLS_LD:  mar_ld_q    <= 1'b1;
                default: reg_in_en_q <= 1'b0;
              endcase
            end
          end
          S_EX: begin
            if (decClass == CLS_LD) begin
              state_q  <= S_LDM;
              mem_rd_q <= 1'b1;
            end else begin
              state_q      <= S_F0;
              reg_out_en_q <= 1'b1;
            end
          end
          S_LDM: begin
            // The load writeback shares the following F0 cycle; the PC is not read until F1.
            if (mem_ready) begin
              state_q      <= S_F0;
              reg_in_en_q  <= 1'b1;
              dst_sel_q    <= decRd;
              reg_out_en_q <= 1'b1;
            end else begin
              mem_rd_q <= 1'b1;
            end
          end
          S_HALT: begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
          default: begin
            state_q      <= S_F0;
            reg_out_en_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign src_sel    = src_sel_q;
  assign dst_sel    = dst_sel_q;
  assign reg_in_en  = reg_in_en_q;
  assign reg_out_en = reg_out_en_q;
  assign pc_inc     = pc_inc_q;
  assign mar_ld     = mar_ld_q;
  assign mem_rd     = mem_rd_q;
  assign alu_op     = alu_op_q;
  assign alu_out_en = alu_out_en_q;
  assign ir         = ir_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: per-cycle stimulus and expected strobes are queued,
// then replayed one clock at a time and compared with immediate assertions.
module tb_control_unit;

`ifdef TINY16_ILLEGAL_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        mem_ready;
  logic        zero_flag;
  logic [2:0]  src_sel, dst_sel, alu_op;
  logic        reg_in_en, reg_out_en, pc_inc, mar_ld, mem_rd, alu_out_en, halted;
  logic [15:0] ir;
  logic [15:0] obsVec;

  typedef struct {
    string       tag;
    logic        rdy;
    logic [15:0] bus;
    logic        zf;
    logic [15:0] expVec;
    logic [15:0] expIr;
  } step_t;

  step_t       sb[$];
  logic [15:0] modelIr;
  int          nChecks = 0;
  int          nFail   = 0;

  control_unit #(.OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .mem_ready  (mem_ready),
    .zero_flag  (zero_flag),
    .src_sel    (src_sel),
    .dst_sel    (dst_sel),
    .reg_in_en  (reg_in_en),
    .reg_out_en (reg_out_en),
    .pc_inc     (pc_inc),
    .mar_ld     (mar_ld),
    .mem_rd     (mem_rd),
    .alu_op     (alu_op),
    .alu_out_en (alu_out_en),
    .ir         (ir),
    .halted     (halted)
  );

  assign obsVec = {src_sel, dst_sel, reg_in_en, reg_out_en, pc_inc, mar_ld, mem_rd,
                   alu_op, alu_out_en, halted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] vec(input logic [2:0] src, input logic [2:0] dst,
                                      input logic rin, input logic rout, input logic pci,
                                      input logic mar, input logic mrd, input logic [2:0] alu,
                                      input logic aluo, input logic hlt);
    return {src, dst, rin, rout, pci, mar, mrd, alu, aluo, hlt};
  endfunction

  task automatic push(input string tag, input logic rdy, input logic [15:0] bus,
                      input logic zf, input logic [15:0] ev, input logic [15:0] eir);
    step_t s;
    s.tag = tag; s.rdy = rdy; s.bus = bus; s.zf = zf; s.expVec = ev; s.expIr = eir;
    sb.push_back(s);
  endtask

  // Reference sequencing: queues F1 through the closing F0 (or HALT) of one instruction.
  task automatic queueInstr(input logic [15:0] w, input int fWait, input int lWait,
                            input logic zf, input logic junk);
    logic [3:0]  op;
    logic [2:0]  rd, rs, aluExp;
    logic        rout, illegal, halts;
    logic [15:0] exVec;
    op      = w[15:12];
    rd      = w[11:9];
    rs      = w[8:6];
    aluExp  = 3'(op - 4'd2);
    rout    = op inside {4'h1, 4'h7, 4'h8, 4'h9};
    illegal = op inside {[4'hA:4'hE]};
    halts   = (op == 4'hF) || (illegal && Trap);

    push($sformatf("%h/F1", w), junk, 16'h0, zf, vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), modelIr);
    for (int i = 0; i <= fWait; i++)
      push($sformatf("%h/F2.%0d", w, i), (i == fWait), (i == fWait) ? w : 16'h0, zf,
           vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), modelIr);
    modelIr = w;
    push($sformatf("%h/DEC", w), 1'b0, 16'h0, zf, vec(rs, rd, 0, rout, 1, 0, 0, 0, 0, 0), modelIr);

    if (halts) begin
      for (int i = 0; i < 3; i++)
        push($sformatf("%h/HALT.%0d", w, i), 1'b1, 16'h0, zf,
             vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), modelIr);
      return;
    end
    if (op == 4'h0 || illegal) begin
      push($sformatf("%h/F0", w), 1'b0, 16'h0, zf, vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), modelIr);
      return;
    end

    case (op)
      4'h1:                     exVec = vec(0, rd, 1, 0, 0, 0, 0, 0, 0, 0);
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
                                exVec = vec(0, rd, 1, 0, 0, 0, 0, aluExp, 1, 0);
      4'h7:                     exVec = vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      4'h8:                     exVec = vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      default:                  exVec = vec(0, 0, zf, 0, 0, 0, 0, 0, 0, 0);
    endcase
    push($sformatf("%h/EX", w), junk, 16'h0, zf, exVec, modelIr);

    if (op == 4'h7) begin
      for (int i = 0; i <= lWait; i++)
        push($sformatf("%h/LDM.%0d", w, i), (i == lWait), (i == lWait) ? 16'hBEEF : 16'h0, zf,
             vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), modelIr);
      push($sformatf("%h/F0wb", w), 1'b0, 16'h0, zf, vec(0, rd, 1, 1, 0, 0, 0, 0, 0, 0), modelIr);
    end else begin
      push($sformatf("%h/F0", w), 1'b0, 16'h0, zf, vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), modelIr);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drains the scoreboard: drive each step just after the rising edge, compare on the falling edge.
  task automatic applyStimulus();
    step_t s;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      s = sb.pop_front();
      mem_ready = s.rdy;
      bus_in    = s.bus;
      zero_flag = s.zf;
      @(negedge clk);
      checkOutput($sformatf("%s/ctl", s.tag), obsVec, s.expVec);
      checkOutput($sformatf("%s/ir", s.tag), ir, s.expIr);
    end
    mem_ready = 1'b0;
    bus_in    = 16'h0;
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  aluOps [4];
    aluOps = '{4'h2, 4'h4, 4'h5, 4'h6};
    rst_n     = 1'b0;
    bus_in    = 16'h0;
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    modelIr   = 16'h0;
    $display("[TB] control_unit bench start (trap=%0d)", Trap);

    repeat (2) @(negedge clk);
    checkOutput("reset/ctl", obsVec, 16'h0);
    checkOutput("reset/ir", ir, 16'h0);
    rst_n = 1'b1;

    push("rst/F0", 1'b0, 16'h0, 1'b0, vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 16'h0);
    push("rst/F1", 1'b0, 16'h0, 1'b0, vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 16'h0);
    push("rst/F2.0", 1'b0, 16'h0, 1'b0, vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 16'h0);
    push("rst/F2.1", 1'b0, 16'h0, 1'b0, vec(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 16'h0);
    applyStimulus();

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset mem_rd", {15'h0, mem_rd}, 16'h0);
    checkOutput("async reset ctl", obsVec, 16'h0);
    @(negedge clk);
    checkOutput("held reset ctl", obsVec, 16'h0);
    rst_n   = 1'b1;
    modelIr = 16'h0;

    push("rel/F0", 1'b0, 16'h0, 1'b0, vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 16'h0);
    queueInstr(16'h1280, 0, 0, 1'b0, 1'b1);
    queueInstr(16'h3A40, 2, 0, 1'b0, 1'b0);
    queueInstr(16'h70C0, 0, 3, 1'b0, 1'b1);
    queueInstr(16'h9080, 0, 0, 1'b0, 1'b0);
    queueInstr(16'h9080, 1, 0, 1'b1, 1'b0);
    queueInstr(16'h8000, 0, 0, 1'b0, 1'b0);
    applyStimulus();

    for (int i = 0; i < 4; i++) begin
      w = {aluOps[i], 3'($urandom_range(7)), 3'($urandom_range(7)), 6'h15};
      queueInstr(w, i % 2, 0, 1'b0, 1'b1);
    end
    queueInstr(16'h0000, 0, 0, 1'b0, 1'b1);
    queueInstr(16'hB000, 0, 0, 1'b0, 1'b0);
`ifndef TINY16_ILLEGAL_TRAP_EN
    queueInstr(16'hF000, 1, 0, 1'b0, 1'b0);
`endif
    applyStimulus();

    rst_n = 1'b0;
    #1;
    checkOutput("final reset ctl", obsVec, 16'h0);
    checkOutput("final reset ir", ir, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
